// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory slave family.
package apb_pkg;

  // Transfer FSM: waiting for a setup phase, or inside the access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Largest programmable wait-state count and the counter width it needs.
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  // Default geometry, matching the fixed 64x32 slave this block replaces.
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 64;

  // Number of byte lanes in a data word.
  function automatic int byte_lanes(input int unsigned data_w);
    return int'(data_w / 8);
  endfunction

  // Width of a word index into a memory of the given depth.
  function automatic int index_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_bram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. Array contents have no reset so they survive a bus reset.
module apb_bram_be
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int LANES = byte_lanes(DATA_W),
  localparam int IDX_W = index_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LANES-1:0]  we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Update only the byte lanes whose enable is set; storage is never cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read register: cleared by reset or by an errored read, otherwise it
  // loads on an accepted read and holds its value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 memory slave: byte strobes, programmable read/write wait
// states, registered PREADY/PRDATA and PSLVERR on out-of-range or misaligned
// addresses.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned WAIT_RD   = 0,
  parameter int unsigned WAIT_WR   = 0,
  localparam int LANES = byte_lanes(DATA_W),
  localparam int IDX_W = index_width(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [LANES-1:0]  PSTRB,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int                OFF_W      = $clog2(LANES);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  RD_WAIT    = CNT_W'(WAIT_RD);
  localparam logic [CNT_W-1:0]  WR_WAIT    = CNT_W'(WAIT_WR);

  apb_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, wait_load;
  logic              pready_n, pslverr_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic              wr_q, wr_n;
  logic              err_q, err_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [LANES-1:0]  strb_q, strb_n;

  logic [ADDR_W-1:0] offset, word_off;
  logic [IDX_W-1:0]  addr_idx;
  logic              addr_err;
  logic              setup, complete;
  logic [IDX_W-1:0]  ram_addr;
  logic [LANES-1:0]  ram_we;

  // Decode the bus address into a word index and an error flag
  // (below base, past the end, or not word aligned).
  always_comb begin
    offset   = PADDR - BASE;
    word_off = offset >> OFF_W;
    addr_idx = word_off[IDX_W-1:0];
    addr_err = (PADDR < BASE) || (word_off >= DEPTH_A) ||
               ((PADDR & ALIGN_MASK) != '0);
  end

  // Bus phase qualifiers; PSEL with PENABLE in IDLE is deliberately not a setup.
  always_comb begin
    setup     = (state == IDLE) && PSEL && !PENABLE;
    complete  = (state == ACCESS) && PSEL && PENABLE && PREADY;
    wait_load = PWRITE ? WR_WAIT : RD_WAIT;
  end

  // Next-state logic: latch the request on setup, count down wait states
  // (saturating at zero), and return to IDLE on completion or master abort.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pready_n  = PREADY;
    pslverr_n = PSLVERR;
    idx_n     = idx_q;
    wr_n      = wr_q;
    err_n     = err_q;
    wdata_n   = wdata_q;
    strb_n    = strb_q;
    case (state)
      IDLE: begin
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        if (setup) begin
          state_n   = ACCESS;
          cnt_n     = wait_load;
          pready_n  = (wait_load == '0);
          pslverr_n = (wait_load == '0) && addr_err;
          idx_n     = addr_idx;
          wr_n      = PWRITE;
          err_n     = addr_err;
          wdata_n   = PWDATA;
          strb_n    = PSTRB;
        end
      end
      ACCESS: begin
        if (!PSEL || complete) begin
          state_n   = IDLE;
          cnt_n     = '0;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
        end else if (cnt != '0) begin
          cnt_n     = cnt - 1'b1;
          pready_n  = (cnt == CNT_W'(1));
          pslverr_n = (cnt == CNT_W'(1)) && err_q;
        end
      end
      default: begin
        state_n   = IDLE;
        cnt_n     = '0;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      PREADY  <= pready_n;
      PSLVERR <= pslverr_n;
      idx_q   <= idx_n;
      wr_q    <= wr_n;
      err_q   <= err_n;
      wdata_q <= wdata_n;
      strb_q  <= strb_n;
    end
  end

  // Reads use the live address at setup; writes use the latched address at
  // the completing edge, so the single port is never contended.
  always_comb begin
    ram_addr = (state == IDLE) ? addr_idx : idx_q;
    ram_we   = (complete && wr_q && !err_q) ? strb_q : '0;
  end

  apb_bram_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (PCLK),
    .rst    (PRESET),
    .addr   (ram_addr),
    .we     (ram_we),
    .wdata  (wdata_q),
    .rd_en  (setup && !PWRITE && !addr_err),
    .rd_clr (setup && !PWRITE && addr_err),
    .rdata  (PRDATA)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: three slave instances (default, wait states, 16-bit
// with non-zero base) on a shared bus, checked against a byte-level model.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] rdata0, rdata1;
  logic [15:0] rdata2;
  logic [2:0]  ready, slverr;

  int compared   = 0;
  int mismatched = 0;

  // Instance geometry as the model sees it
  int          lanes_of   [3] = '{4, 4, 2};
  logic [31:0] base_of    [3] = '{32'h0, 32'h0, 32'h400};
  int          wait_rd_of [3] = '{0, 3, 0};
  int          wait_wr_of [3] = '{0, 2, 0};
  logic [7:0]  ref_mem [3][256];

  always #5 clk = ~clk;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(0),
                  .WAIT_RD(0), .WAIT_WR(0)) u_dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(sel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(rdata0),
    .PREADY(ready[0]), .PSLVERR(slverr[0]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(0),
                  .WAIT_RD(3), .WAIT_WR(2)) u_dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(sel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(rdata1),
    .PREADY(ready[1]), .PSLVERR(slverr[1]));

  apb_mem_slave #(.DATA_W(16), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(32'h400),
                  .WAIT_RD(0), .WAIT_WR(0)) u_dut2 (
    .PCLK(clk), .PRESET(rst), .PSEL(sel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata[15:0]), .PSTRB(pstrb[1:0]), .PRDATA(rdata2),
    .PREADY(ready[2]), .PSLVERR(slverr[2]));

  function automatic logic [31:0] get_rdata(input int i);
    case (i)
      0:       return rdata0;
      1:       return rdata1;
      default: return {16'h0, rdata2};
    endcase
  endfunction

  // Error rule: below base, at or past base + 64 words, or unaligned
  function automatic bit model_err(input int i, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - base_of[i];
    return (addr < base_of[i]) || (off >= 32'(64 * lanes_of[i])) ||
           ((addr % 32'(lanes_of[i])) != 0);
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [31:0] addr);
    logic [31:0] off, val;
    val = '0;
    if (model_err(i, addr)) return 32'h0;
    off = addr - base_of[i];
    for (int b = 0; b < lanes_of[i]; b++) val[b*8 +: 8] = ref_mem[i][off + 32'(b)];
    return val;
  endfunction

  task automatic model_write(input int i, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] off;
    if (model_err(i, addr)) return;
    off = addr - base_of[i];
    for (int b = 0; b < lanes_of[i]; b++)
      if (strb[b]) ref_mem[i][off + 32'(b)] = data[b*8 +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One full transfer starting just after a rising edge; leaves the bus idle
  // one step after the completing edge so calls chain back-to-back.
  task automatic applyStimulus(input int i, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input string tag);
    int waits;
    bit exp_err;
    int exp_waits;
    exp_err   = model_err(i, addr);
    exp_waits = wr ? wait_wr_of[i] : wait_rd_of[i];
    sel = 3'b001 << i; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (ready[i] !== 1'b1 && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    checkOutput({tag, " waits"}, 32'(waits), 32'(exp_waits));
    checkOutput({tag, " pslverr"}, {31'b0, slverr[i]}, {31'b0, exp_err});
    if (!wr) checkOutput({tag, " prdata"}, get_rdata(i), model_read(i, addr));
    else     model_write(i, addr, data, strb);
    @(posedge clk); #1;
    sel = '0; penable = 1'b0;
    checkOutput({tag, " pready after"}, {31'b0, ready[i]}, 32'h0);
  endtask

  initial begin
    int          i;
    int          off;
    logic [31:0] addr;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pready",  {29'b0, ready},  32'h0);
    checkOutput("reset pslverr", {29'b0, slverr}, 32'h0);
    checkOutput("reset prdata0", rdata0, 32'h0);
    checkOutput("reset prdata2", {16'h0, rdata2}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill every word so the model knows all contents
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 64; w++)
        applyStimulus(k, 1'b1, base_of[k] + 32'(w * lanes_of[k]), $urandom, 4'hF, "preload");

    // Zero-wait write then read
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "zw write");
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, "zw read");
    checkOutput("zw deadbeef", rdata0, 32'hDEADBEEF);

    // Byte strobes
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "strb preload");
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "strb write");
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF, "strb read");
    checkOutput("strb merged", rdata0, 32'h11BB33DD);
    applyStimulus(0, 1'b1, 32'h20, 32'h0, 4'h0, "strb none");

    // Wait states
    applyStimulus(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, "ws write");
    applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'h0, "ws read");
    checkOutput("ws cafef00d", rdata1, 32'hCAFEF00D);

    // Errors
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'h0, "err range");
    checkOutput("err prdata zero", rdata0, 32'h0);
    applyStimulus(0, 1'b1, 32'h00, 32'h12345678, 4'hF, "err preload");
    applyStimulus(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, "err misaligned");
    applyStimulus(0, 1'b0, 32'h00, 32'h0, 4'h0, "err readback");
    checkOutput("err mem kept", rdata0, 32'h12345678);

    // Master abort during a write wait state
    sel = 3'b010; pwrite = 1'b1; paddr = 32'h44; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    sel = '0; penable = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort pready",  {31'b0, ready[1]},  32'h0);
    checkOutput("abort pslverr", {31'b0, slverr[1]}, 32'h0);
    applyStimulus(1, 1'b0, 32'h44, 32'h0, 4'h0, "abort readback");

    // Reset in the middle of a write access
    sel = 3'b010; pwrite = 1'b1; paddr = 32'h48; pwdata = 32'h5EED5EED; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst pready",  {29'b0, ready},  32'h0);
    checkOutput("midrst pslverr", {29'b0, slverr}, 32'h0);
    checkOutput("midrst prdata0", rdata0, 32'h0);
    checkOutput("midrst prdata1", rdata1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; sel = '0; penable = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 32'h48, 32'h0, 4'h0, "midrst readback");

    // 16-bit instance with base 0x400
    applyStimulus(2, 1'b1, 32'h402, 32'h0000BEEF, 4'h3, "w16 write");
    applyStimulus(2, 1'b0, 32'h402, 32'h0, 4'h0, "w16 read");
    checkOutput("w16 beef", {16'h0, rdata2}, 32'h0000BEEF);
    applyStimulus(2, 1'b0, 32'h3FE, 32'h0, 4'h0, "w16 below base");
    applyStimulus(2, 1'b0, 32'h401, 32'h0, 4'h0, "w16 misaligned");
    applyStimulus(2, 1'b0, 32'h480, 32'h0, 4'h0, "w16 past end");

    // Randomized mix across all instances, in and out of range
    for (int n = 0; n < 120; n++) begin
      i    = int'($urandom_range(0, 2));
      off  = int'($urandom_range(0, 64 * lanes_of[i] + 31)) - 16;
      addr = base_of[i] + 32'(off);
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(lanes_of[i] - 1);
      applyStimulus(i, 1'($urandom_range(0, 1)), addr, $urandom,
                    4'($urandom_range(0, 15)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory slave, successor to the fixed 64×32 slave currently on the APB bus. Adds configurable data width, depth and base address, byte write strobes, programmable read/write wait states, registered read data and PSLVERR for out-of-range or misaligned accesses. Sits behind the APB decoder alongside the GPIO and UART slaves, one PSEL per instance.

## Interface
- DATA_W, 32: data width; must be 8, 16 or 32.
- ADDR_W, 32: PADDR width.
- DEPTH, 64: number of DATA_W words; power of two, ≥2.
- BASE_ADDR, 0: byte address of word 0; aligned to DEPTH*DATA_W/8.
- WAIT_RD, 0: wait states inserted on reads (0–15).
- WAIT_WR, 0: wait states inserted on writes (0–15).

- PCLK  in  1  clock, all state on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte write enables.
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  error, valid only while PREADY=1.

## Operation
- Offset = PADDR − BASE_ADDR; index = offset >> log2(DATA_W/8).
- Error when offset < 0 (unsigned underflow), offset ≥ DEPTH*DATA_W/8, or low log2(DATA_W/8) bits of PADDR non-zero.
- FSM states IDLE, ACCESS.
  - IDLE: on PSEL=1, PENABLE=0, latch PADDR/PWRITE/PWDATA/PSTRB and the error flag; load cnt with WAIT_WR or WAIT_RD; go to ACCESS.
  - ACCESS: while cnt>0, decrement each cycle. PREADY is 1 when cnt=0.
  - On a PSEL=1, PENABLE=1, PREADY=1 edge, the transfer completes. Return to IDLE, PREADY←0, PSLVERR←0.
  - ACCESS with PSEL=0 (master abort): return to IDLE, no write, PREADY←0.
- Write: commits at the completing edge. Only bytes with PSTRB set are updated. PSTRB=0 gives an OK, no-op transfer. On an error, memory is unchanged.
- Read: PRDATA←mem[index] (0 if error) at the edge entering ACCESS. It holds until the next read.
- PSTRB is ignored on reads.
- PSEL=1, PENABLE=1 seen in IDLE is a protocol violation. It is ignored and PREADY stays 0.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, cnt=0. Memory contents are not reset and are retained across reset.
- Reset mid-transfer aborts it; no write occurs.
- Setup in cycle T gives PREADY=1 in cycle T+1+WAIT. Zero-wait transfer = 2 cycles.
- PSLVERR is asserted in the same cycle as PREADY.
- Back-to-back: a new setup is accepted in the cycle after completion.
- A read immediately after a write to the same word returns the new data.
- Wait-state counter never wraps. It saturates at 0.

## Structure
- Package apb_pkg:
  - state enum typedef (IDLE, ACCESS);
  - localparams for byte-lane count and index width derived from DATA_W/DEPTH;
  - WAIT max constant.
- Sub-module apb_bram_be: single-port synchronous RAM with per-byte write enable and registered read.

## Test plan
- Zero-wait, default params: write 0xDEADBEEF to 0x10, PSTRB=4'hF, then read 0x10. Each transfer has PREADY=1 in its second cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
- Byte strobe: preload 0x11223344 at 0x20, write 0xAABBCCDD with PSTRB=4'b0101. A read returns 0x11BB33DD.
- WAIT_RD=3, WAIT_WR=2: read has PREADY high 4 cycles after setup; write completes 3 cycles after setup; PREADY is 0 during all waits.
- Errors: read 0x100 (DEPTH=64) gives PSLVERR=1, PRDATA=0. Write to 0x02 gives PSLVERR=1 and memory at 0x00 unchanged.
- Abort and reset: drop PSEL during a wait state, or assert PRESET mid-access. No write occurs; all outputs read 0; the next transfer completes normally.
- Width variant DATA_W=16, BASE_ADDR=0x400: write 0xBEEF to 0x402, read it back correctly. Address 0x3FE gives PSLVERR.
